// File: rtl/commit_halt_monitor.sv
// rtl/commit_halt_monitor.sv - commit ordering, self-loop halt detection and stall watchdog
`timescale 1ns/1ps
module commit_halt_monitor #(
    parameter int NUM_CH         = 2,
    parameter int DRAIN_DELAY    = 5,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int ORDER_W        = 64,
    parameter int PC_W           = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         commit,
    input  logic [NUM_CH*32-1:0]      inst,
    input  logic [NUM_CH*PC_W-1:0]    pc_rdata,
    input  logic [NUM_CH*PC_W-1:0]    pc_wdata,
    output logic [NUM_CH*ORDER_W-1:0] order,
    output logic [ORDER_W-1:0]        commit_count,
    output logic                      loop_seen,
    output logic                      halt,
    output logic                      timed_out,
    output logic [1:0]                state
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_DRAIN   = 2'b01,
        ST_HALTED  = 2'b10,
        ST_TIMEOUT = 2'b11
    } state_t;

    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6f;

    localparam int DRAIN_W = (DRAIN_DELAY > 0) ? $clog2(DRAIN_DELAY + 1) : 1;
    localparam int IDLE_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit WD_EN   = (TIMEOUT_CYCLES != 0);

    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_DELAY);
    localparam logic [IDLE_W-1:0]  IDLE_LAST  = WD_EN ? IDLE_W'(TIMEOUT_CYCLES - 1) : '0;

    state_t              state_q, state_nxt;
    logic [DRAIN_W-1:0]  drain_cnt, drain_nxt;
    logic [IDLE_W-1:0]   idle_cnt, idle_nxt;
    logic [ORDER_W-1:0]  count_nxt;
    logic [ORDER_W-1:0]  base;
    logic [NUM_CH-1:0]   accepted;
    logic                any_acc;
    logic                loop_det;
    logic                wd_expire;
    logic                unused_inst_bits;

    // Only the opcode field matters for halt detection.
    assign unused_inst_bits = ^inst;

    assign accepted = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) ? commit : '0;
    assign any_acc  = |accepted;

    // Running base walks the channels oldest-first so gaps compact naturally.
    always_comb begin
        base  = commit_count;
        order = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            order[i*ORDER_W +: ORDER_W] = base;
            if (accepted[i]) begin
                base = base + ORDER_W'(1);
            end
        end
        count_nxt = base;
    end

    always_comb begin
        loop_det = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (commit[i]
                && (pc_wdata[i*PC_W +: PC_W] == pc_rdata[i*PC_W +: PC_W])
                && ((inst[i*32 +: 7] == OP_BRANCH) || (inst[i*32 +: 7] == OP_JAL))) begin
                loop_det = 1'b1;
            end
        end
    end

    assign wd_expire = WD_EN && !any_acc && (idle_cnt == IDLE_LAST);

    always_comb begin
        state_nxt = state_q;
        drain_nxt = drain_cnt;
        idle_nxt  = idle_cnt;
        case (state_q)
            ST_RUN: begin
                if (any_acc) begin
                    idle_nxt = '0;
                end else if (WD_EN) begin
                    idle_nxt = idle_cnt + IDLE_W'(1);
                end
                // Loop detection takes priority over a coincident watchdog expiry.
                if (loop_det) begin
                    drain_nxt = '0;
                    state_nxt = (DRAIN_DELAY == 0) ? ST_HALTED : ST_DRAIN;
                end else if (wd_expire) begin
                    state_nxt = ST_TIMEOUT;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    state_nxt = ST_HALTED;
                end else begin
                    drain_nxt = drain_cnt + DRAIN_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RUN;
            commit_count <= '0;
            drain_cnt    <= '0;
            idle_cnt     <= '0;
            loop_seen    <= 1'b0;
            halt         <= 1'b0;
            timed_out    <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            commit_count <= count_nxt;
            drain_cnt    <= drain_nxt;
            idle_cnt     <= idle_nxt;
            loop_seen    <= (state_nxt == ST_DRAIN) || (state_nxt == ST_HALTED);
            halt         <= (state_nxt == ST_HALTED);
            timed_out    <= (state_nxt == ST_TIMEOUT);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_commit_halt_monitor.sv
// tb/tb_commit_halt_monitor.sv - randomized self-checking bench for commit_halt_monitor
`timescale 1ns/1ps
module tb_commit_halt_monitor;

    localparam int PC_W = 32;
    localparam int A_CH = 2, A_D = 5, A_T = 8, A_W = 4;
    localparam int B_CH = 4, B_D = 0, B_T = 0, B_W = 8;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [A_CH-1:0]      commit_a;
    logic [A_CH*32-1:0]   inst_a, pcr_a, pcw_a;
    logic [A_CH*A_W-1:0]  order_a;
    logic [A_W-1:0]       count_a;
    logic                 ls_a, h_a, to_a;
    logic [1:0]           st_a;

    logic [B_CH-1:0]      commit_b;
    logic [B_CH*32-1:0]   inst_b, pcr_b, pcw_b;
    logic [B_CH*B_W-1:0]  order_b;
    logic [B_W-1:0]       count_b;
    logic                 ls_b, h_b, to_b;
    logic [1:0]           st_b;

    commit_halt_monitor #(.NUM_CH(A_CH), .DRAIN_DELAY(A_D), .TIMEOUT_CYCLES(A_T),
                          .ORDER_W(A_W), .PC_W(PC_W)) dut_a (
        .clk(clk), .rst(rst), .commit(commit_a), .inst(inst_a),
        .pc_rdata(pcr_a), .pc_wdata(pcw_a), .order(order_a), .commit_count(count_a),
        .loop_seen(ls_a), .halt(h_a), .timed_out(to_a), .state(st_a));

    commit_halt_monitor #(.NUM_CH(B_CH), .DRAIN_DELAY(B_D), .TIMEOUT_CYCLES(B_T),
                          .ORDER_W(B_W), .PC_W(PC_W)) dut_b (
        .clk(clk), .rst(rst), .commit(commit_b), .inst(inst_b),
        .pc_rdata(pcr_b), .pc_wdata(pcw_b), .order(order_b), .commit_count(count_b),
        .loop_seen(ls_b), .halt(h_b), .timed_out(to_b), .state(st_b));

    always #5 clk = ~clk;

    // st: 0 run, 1 draining, 2 halted, 3 timed out
    typedef struct packed {
        logic [1:0]  st;
        logic [63:0] cnt;
        logic [31:0] drain;
        logic [31:0] idle;
    } mdl_t;

    mdl_t ma, mb;
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mask(input int w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input logic [3:0] cm, input logic [127:0] in,
                                      input logic [127:0] pr, input logic [127:0] pw,
                                      input int nch, input int d, input int t, input int w);
        mdl_t r;
        int   n;
        bit   loop;
        bit   live;
        r    = m;
        n    = 0;
        loop = 0;
        live = (m.st == 2'd0) || (m.st == 2'd1);
        for (int i = 0; i < nch; i++) begin
            if (cm[i]) begin
                if (live) n++;
                if (pr[32*i +: 32] == pw[32*i +: 32]
                    && (in[32*i +: 7] == 7'h63 || in[32*i +: 7] == 7'h6f)) loop = 1;
            end
        end
        r.cnt = (m.cnt + 64'(n)) & mask(w);
        if (m.st == 2'd0) begin
            if (loop) begin
                r.st    = (d == 0) ? 2'd2 : 2'd1;
                r.drain = 0;
            end else if (t != 0 && n == 0 && m.idle == 32'(t - 1)) begin
                r.st = 2'd3;
            end
            r.idle = (n > 0) ? 0 : ((t != 0) ? m.idle + 1 : 0);
        end else if (m.st == 2'd1) begin
            if (m.drain == 32'(d)) r.st = 2'd2;
            else r.drain = m.drain + 1;
        end
        return r;
    endfunction

    task automatic check_orders(input string p, input mdl_t m, input logic [3:0] cm,
                                input logic [255:0] ord, input int nch, input int w);
        int          k;
        logic [63:0] got;
        logic [63:0] exp;
        k = 0;
        for (int i = 0; i < nch; i++) begin
            if (cm[i]) begin
                exp = (m.cnt + (((m.st == 2'd0) || (m.st == 2'd1)) ? 64'(k) : 64'd0)) & mask(w);
                got = 64'(ord >> (w * i)) & mask(w);
                check($sformatf("%s.order%0d", p, i), got, exp);
                k++;
            end
        end
    endtask

    task automatic check_regs(input string p, input mdl_t m, input logic [63:0] cnt,
                              input logic [1:0] st, input logic ls, input logic h, input logic to);
        check({p, ".count"},     cnt,    m.cnt);
        check({p, ".state"},     64'(st), 64'(m.st));
        check({p, ".loop_seen"}, 64'(ls), 64'((m.st == 2'd1) || (m.st == 2'd2)));
        check({p, ".halt"},      64'(h),  64'(m.st == 2'd2));
        check({p, ".timed_out"}, 64'(to), 64'(m.st == 2'd3));
    endtask

    task automatic step();
        #1;
        check_orders("a", ma, 4'(commit_a), 256'(order_a), A_CH, A_W);
        check_orders("b", mb, 4'(commit_b), 256'(order_b), B_CH, B_W);
        @(posedge clk);
        ma = mdl_step(ma, 4'(commit_a), 128'(inst_a), 128'(pcr_a), 128'(pcw_a), A_CH, A_D, A_T, A_W);
        mb = mdl_step(mb, 4'(commit_b), 128'(inst_b), 128'(pcr_b), 128'(pcw_b), B_CH, B_D, B_T, B_W);
        #1;
        check_regs("a", ma, 64'(count_a), st_a, ls_a, h_a, to_a);
        check_regs("b", mb, 64'(count_b), st_b, ls_b, h_b, to_b);
    endtask

    task automatic set_idle();
        commit_a = '0;
        commit_b = '0;
        inst_a   = {A_CH{NOP}};
        inst_b   = {B_CH{NOP}};
        pcr_a    = '0;
        pcr_b    = '0;
        pcw_a    = {A_CH{32'h4}};
        pcw_b    = {B_CH{32'h4}};
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        #1;
        ma = '0;
        mb = '0;
        check_regs("rst.a", ma, 64'(count_a), st_a, ls_a, h_a, to_a);
        check_regs("rst.b", mb, 64'(count_b), st_b, ls_b, h_b, to_b);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic rand_lane(input int lp, output logic [31:0] ins,
                             output logic [31:0] pr, output logic [31:0] pw);
        logic [31:0] r;
        logic [6:0]  op;
        r  = $urandom;
        pr = $urandom & 32'hffff_fffc;
        if ($urandom_range(0, 999) < lp) begin
            op = $urandom_range(0, 1) ? 7'h63 : 7'h6f;
            pw = pr;
        end else begin
            case ($urandom_range(0, 4))
                0: op = 7'h13;
                1: op = 7'h33;
                2: op = 7'h63;
                3: op = 7'h6f;
                default: op = 7'h03;
            endcase
            pw = ($urandom_range(0, 7) == 0) ? pr : pr + 32'd4;
            if (pw == pr && (op == 7'h63 || op == 7'h6f)) op = 7'h67;
        end
        ins = {r[31:7], op};
    endtask

    task automatic drive_rand(input int dens, input int lp);
        logic [31:0] li, lr, lw;
        for (int i = 0; i < A_CH; i++) begin
            commit_a[i] = ($urandom_range(0, 99) < dens);
            rand_lane(lp, li, lr, lw);
            inst_a[32*i +: 32] = li;
            pcr_a[32*i +: 32]  = lr;
            pcw_a[32*i +: 32]  = lw;
        end
        for (int i = 0; i < B_CH; i++) begin
            commit_b[i] = ($urandom_range(0, 99) < dens);
            rand_lane(lp, li, lr, lw);
            inst_b[32*i +: 32] = li;
            pcr_b[32*i +: 32]  = lr;
            pcw_b[32*i +: 32]  = lw;
        end
    endtask

    logic [63:0] saved;

    initial begin
        set_idle();
        #1;

        // dense back-to-back commits from reset
        do_reset();
        commit_a = 2'b11;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("s1.ord0", 64'(order_a[3:0]), 64'(2 * c));
            check("s1.ord1", 64'(order_a[7:4]), 64'(2 * c + 1));
            step();
        end
        check("s1.count", 64'(count_a), 64'd6);

        // gapped commit vector on the four-channel instance
        do_reset();
        commit_b = 4'b1111;
        step();
        step();
        commit_b = 4'b0011;
        step();
        check("s2.count10", 64'(count_b), 64'd10);
        commit_b = 4'b1010;
        #1;
        check("s2.ord1", 64'(order_b[15:8]), 64'd10);
        check("s2.ord3", 64'(order_b[31:24]), 64'd11);
        step();
        check("s2.count12", 64'(count_b), 64'd12);

        // order counter wrap on the 4-bit instance
        do_reset();
        commit_a = 2'b11;
        for (int c = 0; c < 7; c++) step();
        commit_a = 2'b01;
        step();
        check("s3.count15", 64'(count_a), 64'd15);
        commit_a = 2'b11;
        #1;
        check("s3.ord0", 64'(order_a[3:0]), 64'd15);
        check("s3.ord1", 64'(order_a[7:4]), 64'd0);
        step();
        check("s3.wrap", 64'(count_a), 64'd1);

        // loop detection with drain, and immediate halt when the drain delay is zero
        do_reset();
        for (int c = 0; c < 19; c++) begin
            drive_rand(80, 0);
            step();
        end
        drive_rand(80, 0);
        commit_a = 2'b10;
        inst_a[63:32] = 32'h0000_0063;
        pcr_a[63:32]  = 32'h8000_0040;
        pcw_a[63:32]  = 32'h8000_0040;
        commit_b = 4'b0100;
        inst_b[95:64] = 32'h0000_006f;
        pcr_b[95:64]  = 32'h8000_0100;
        pcw_b[95:64]  = 32'h8000_0100;
        step();
        check("s4.loop_seen", 64'(ls_a), 64'd1);
        check("s4.drain", 64'(st_a), 64'd1);
        check("s4.b_halt", 64'(h_b), 64'd1);
        check("s4.b_loop_seen", 64'(ls_b), 64'd1);
        for (int k = 1; k <= 5; k++) begin
            drive_rand(90, 500);
            step();
        end
        check("s4.halt_early", 64'(h_a), 64'd0);
        drive_rand(90, 0);
        step();
        check("s4.halt", 64'(h_a), 64'd1);
        saved = ma.cnt;
        for (int k = 0; k < 4; k++) begin
            drive_rand(100, 0);
            step();
        end
        check("s4.frozen", 64'(count_a), saved);

        // stall watchdog
        do_reset();
        commit_a = 2'b01;
        for (int c = 0; c < 3; c++) step();
        commit_a = 2'b00;
        for (int c = 0; c < 7; c++) step();
        check("s5.not_yet", 64'(st_a), 64'd0);
        step();
        check("s5.state", 64'(st_a), 64'd3);
        check("s5.timed_out", 64'(to_a), 64'd1);
        check("s5.no_halt", 64'(h_a), 64'd0);
        commit_a = 2'b11;
        step();
        check("s5.ignored", 64'(count_a), 64'd3);

        // loop commit on the would-be expiry cycle
        do_reset();
        commit_a = 2'b01;
        step();
        commit_a = 2'b00;
        for (int c = 0; c < 7; c++) step();
        commit_a = 2'b01;
        inst_a[31:0] = 32'h0000_0063;
        pcr_a[31:0]  = 32'h8000_0200;
        pcw_a[31:0]  = 32'h8000_0200;
        step();
        check("s6.drain", 64'(st_a), 64'd1);
        check("s6.no_timeout", 64'(to_a), 64'd0);

        // asynchronous reset in the middle of a drain
        set_idle();
        for (int c = 0; c < 3; c++) step();
        rst = 1'b1;
        #1;
        check("s7.count", 64'(count_a), 64'd0);
        check("s7.state", 64'(st_a), 64'd0);
        check("s7.loop_seen", 64'(ls_a), 64'd0);
        check("s7.halt", 64'(h_a), 64'd0);
        check("s7.timed_out", 64'(to_a), 64'd0);
        ma = '0;
        mb = '0;
        @(negedge clk);
        rst = 1'b0;
        commit_a = 2'b01;
        #1;
        check("s7.ord0", 64'(order_a[3:0]), 64'd0);
        step();

        // random phases against the reference model
        for (int ph = 0; ph < 10; ph++) begin
            int dens;
            int lp;
            dens = $urandom_range(5, 95);
            lp   = $urandom_range(0, 60);
            do_reset();
            for (int c = 0; c < 60; c++) begin
                drive_rand(dens, lp);
                step();
                if ($urandom_range(0, 99) == 0) do_reset();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/commit_halt_monitor.md
Name: commit_halt_monitor

Overview:
Parametrised halt-detection and commit-ordering block for the verification top, sized for multi-issue and out-of-order cores.
- Watches up to NUM_CH retire channels per cycle.
- Assigns each committed instruction its monotonically increasing order number.
- Detects the self-looping branch/jump that ends a test program, drains for a programmable delay, then asserts halt.
- A stall watchdog flags a timeout when nothing commits for TIMEOUT_CYCLES.

Parameters:
NUM_CH, 2, number of commit channels (1..4); channel 0 is oldest within a cycle
DRAIN_DELAY, 5, cycles between loop detection and halt assertion (0 = halt on next cycle)
TIMEOUT_CYCLES, 100000, commit-free cycles before timeout; 0 disables the watchdog
ORDER_W, 64, order counter width
PC_W, 32, program counter width

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
commit  in  NUM_CH  per-channel valid retire this cycle
inst  in  NUM_CH*32  retired instruction word, channel i at [32i+31:32i]
pc_rdata  in  NUM_CH*PC_W  PC of retired instruction
pc_wdata  in  NUM_CH*PC_W  next PC of retired instruction
order  out  NUM_CH*ORDER_W  order number of channel i's instruction this cycle
commit_count  out  ORDER_W  registered total commits accepted
loop_seen  out  1  registered; loop detected, drain in progress or done
halt  out  1  registered; program finished
timed_out  out  1  registered; watchdog expired
state  out  2  00 RUN, 01 DRAIN, 10 HALTED, 11 TIMEOUT

Behaviour:
- Reset (async, any time including mid-drain):
  - state=RUN; commit_count=0; drain and idle counters=0.
  - loop_seen=0, halt=0, timed_out=0.
- Accepted commit: commit[i]=1 while state is RUN or DRAIN. Commits in HALTED/TIMEOUT are ignored: no count, order outputs hold their last base.
- Order numbering (combinational):
  - order[i] = commit_count + number of accepted commits on channels j<i in the same cycle.
  - Value is meaningful only when commit[i]=1; gaps in the commit vector are compacted (commit=101 gives ch0 base, ch2 base+1).
  - At posedge, commit_count += popcount(accepted commits), modulo 2^ORDER_W (wraps silently).
- Loop detect (per channel, combinational):
  - Condition: commit[i] and pc_wdata[i]==pc_rdata[i] and inst[i][6:0] in {7'h63 branch, 7'h6f JAL}.
  - Channels are OR'd together.
- Watchdog:
  - idle counter clears on any accepted commit, else increments in RUN only.
  - When it reaches TIMEOUT_CYCLES-1 with no commit that cycle, the next state is TIMEOUT.
  - Disabled when TIMEOUT_CYCLES=0.
- FSM:
  - RUN: loop detect -> DRAIN with drain counter cleared, loop_seen=1. Watchdog expiry -> TIMEOUT, timed_out=1. If both occur in the same cycle, the loop wins (DRAIN).
  - DRAIN: drain counter increments each cycle; commits are still accepted; watchdog is frozen. Counter==DRAIN_DELAY -> HALTED.
    - With DRAIN_DELAY=0, RUN goes directly to HALTED in one transition; loop_seen and halt rise together.
    - A further loop detect during DRAIN does not restart the counter.
  - HALTED: halt=1, sticky until reset.
  - TIMEOUT: timed_out=1, sticky until reset; halt stays 0.
- Latency:
  - Loop commit at cycle N: loop_seen=1 after edge N.
  - halt=1 after edge N+DRAIN_DELAY+1.
  - Timeout after edge N+TIMEOUT_CYCLES, where N is the last commit.
- All outputs except order are registered; no combinational path from commit to halt or timed_out.

Test Plan:
- Reset, NUM_CH=2: commit=11 for 3 cycles -> order pairs (0,1),(2,3),(4,5); commit_count=6.
- Gapped commits, NUM_CH=4: commit=1010 with commit_count=10 -> order[1]=10, order[3]=11; commit_count=12 next cycle.
- Loop detection, DRAIN_DELAY=5: ch1 retires inst=0000_0063, pc_rdata=pc_wdata=0x8000_0040 at cycle 20 -> loop_seen=1 after edge 20, state=DRAIN, halt=1 after edge 26; later commits are not counted.
- Watchdog, TIMEOUT_CYCLES=8: last commit at cycle 3 -> timed_out=1, state=11 after edge 11, halt=0.
- Simultaneous events, TIMEOUT_CYCLES=8: loop commit arrives on the cycle the watchdog would expire -> state=DRAIN, timed_out stays 0.
- Async reset mid-drain (drain counter=3) -> all outputs return to reset values immediately without a clock edge; then commit=01 -> order[0]=0.
- Wrap, ORDER_W=4: commit_count=15, commit=11 -> order=(15,0); commit_count=1.
